// File: rtl/sig_pkg.sv
// Shared definitions for the nibble-multiply result checker: state encoding and sizing constants.
package sig_pkg;

    localparam int unsigned SWEEP_LEN = 256;
    localparam int unsigned X_W       = 8;
    localparam int unsigned N_W       = 4;
    localparam int unsigned CNT_W     = 9;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSync = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/sig_ref_model.sv
// Combinational golden model: signed and unsigned 4x4 products of the two stimulus nibbles.
module sig_ref_model
    import sig_pkg::*;
(
    input  logic [X_W-1:0] iX,
    output logic [X_W-1:0] oES,
    output logic [X_W-1:0] oEU
);

    logic signed [X_W-1:0] w_x1_s;
    logic signed [X_W-1:0] w_x2_s;
    logic signed [X_W-1:0] w_es;
    logic        [X_W-1:0] w_x1_u;
    logic        [X_W-1:0] w_x2_u;

    // Extending to the full product width first keeps the low bits of the product exact.
    always_comb begin
        w_x1_s = {{(X_W - N_W){iX[N_W-1]}}, iX[N_W-1:0]};
        w_x2_s = {{(X_W - N_W){iX[X_W-1]}}, iX[X_W-1:N_W]};
        w_x1_u = {{(X_W - N_W){1'b0}}, iX[N_W-1:0]};
        w_x2_u = {{(X_W - N_W){1'b0}}, iX[X_W-1:N_W]};
        w_es   = w_x1_s * w_x2_s;
    end

    assign oES = w_es;
    assign oEU = w_x1_u * w_x2_u;

endmodule

// File: rtl/sig_checker.sv
// Checks one full counter sweep of multiplier outputs, counting mismatches, flagging
// sequence breaks and capturing the first failing vector.
module sig_checker #(
    parameter int unsigned SWEEP_LEN = sig_pkg::SWEEP_LEN
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSTART,
    input  logic [7:0] iX,
    input  logic [7:0] iSY,
    input  logic [7:0] iUY,
    output logic       oBUSY,
    output logic       oDONE,
    output logic       oPASS,
    output logic       oSEQ_ERR,
    output logic [8:0] oERR_CNT,
    output logic [7:0] oFAIL_X,
    output logic [7:0] oFAIL_SY,
    output logic [7:0] oFAIL_UY
);

    localparam int unsigned CW = sig_pkg::CNT_W;
    localparam int unsigned XW = sig_pkg::X_W;
    localparam logic [CW-1:0] LAST_CNT = CW'(SWEEP_LEN);

    sig_pkg::state_e r_state;
    sig_pkg::state_e w_state_d;

    logic [CW-1:0] r_cnt, w_cnt_d, w_cnt_inc;
    logic [CW-1:0] r_err_cnt, w_err_cnt_d;
    logic [XW-1:0] r_prev_x, w_prev_x_d;
    logic [XW-1:0] r_fail_x, w_fail_x_d;
    logic [XW-1:0] r_fail_sy, w_fail_sy_d;
    logic [XW-1:0] r_fail_uy, w_fail_uy_d;
    logic          r_seq_err, w_seq_err_d;
    logic          r_busy, w_busy_d;
    logic          r_done, w_done_d;
    logic          r_pass, w_pass_d;

    logic [XW-1:0] w_es, w_eu;
    logic          w_start, w_check, w_mismatch, w_seq_bad, w_last;

    sig_ref_model u_ref_model (
        .iX  (iX),
        .oES (w_es),
        .oEU (w_eu)
    );

    assign w_start    = iSTART && ((r_state == sig_pkg::StIdle) || (r_state == sig_pkg::StDone));
    assign w_check    = ((r_state == sig_pkg::StSync) && (iX == '0)) ||
                        (r_state == sig_pkg::StRun);
    assign w_mismatch = (iSY != w_es) || (iUY != w_eu);
    assign w_seq_bad  = (r_state == sig_pkg::StRun) && (iX != r_prev_x + XW'(1));
    // The SYNC sample is vector 0, so the count after it is always 1.
    assign w_cnt_inc  = (r_state == sig_pkg::StSync) ? CW'(1) : r_cnt + CW'(1);
    assign w_last     = w_check && (w_cnt_inc == LAST_CNT);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= sig_pkg::StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            sig_pkg::StIdle: if (iSTART) w_state_d = sig_pkg::StSync;
            sig_pkg::StSync: begin
                if (iX == '0) w_state_d = w_last ? sig_pkg::StDone : sig_pkg::StRun;
            end
            sig_pkg::StRun:  if (w_last) w_state_d = sig_pkg::StDone;
            sig_pkg::StDone: if (iSTART) w_state_d = sig_pkg::StSync;
        endcase
    end

    always_comb begin
        w_busy_d = (w_state_d == sig_pkg::StSync) || (w_state_d == sig_pkg::StRun);
        w_done_d = (w_state_d == sig_pkg::StDone);
        w_pass_d = w_done_d && (w_err_cnt_d == '0) && !w_seq_err_d;
    end

    always_comb begin
        w_cnt_d     = r_cnt;
        w_err_cnt_d = r_err_cnt;
        w_prev_x_d  = r_prev_x;
        w_fail_x_d  = r_fail_x;
        w_fail_sy_d = r_fail_sy;
        w_fail_uy_d = r_fail_uy;
        w_seq_err_d = r_seq_err;
        if (w_start) begin
            w_cnt_d     = '0;
            w_err_cnt_d = '0;
            w_fail_x_d  = '0;
            w_fail_sy_d = '0;
            w_fail_uy_d = '0;
            w_seq_err_d = 1'b0;
        end else if (w_check) begin
            w_cnt_d    = w_cnt_inc;
            w_prev_x_d = iX;
            if (w_seq_bad) w_seq_err_d = 1'b1;
            if (w_mismatch) begin
                w_err_cnt_d = r_err_cnt + CW'(1);
                // An empty error count means nothing has been captured yet this run.
                if (r_err_cnt == '0) begin
                    w_fail_x_d  = iX;
                    w_fail_sy_d = iSY;
                    w_fail_uy_d = iUY;
                end
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_cnt     <= '0;
            r_err_cnt <= '0;
            r_prev_x  <= '0;
            r_fail_x  <= '0;
            r_fail_sy <= '0;
            r_fail_uy <= '0;
            r_seq_err <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_d;
            r_err_cnt <= w_err_cnt_d;
            r_prev_x  <= w_prev_x_d;
            r_fail_x  <= w_fail_x_d;
            r_fail_sy <= w_fail_sy_d;
            r_fail_uy <= w_fail_uy_d;
            r_seq_err <= w_seq_err_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_pass    <= w_pass_d;
        end
    end

    assign oBUSY    = r_busy;
    assign oDONE    = r_done;
    assign oPASS    = r_pass;
    assign oSEQ_ERR = r_seq_err;
    assign oERR_CNT = r_err_cnt;
    assign oFAIL_X  = r_fail_x;
    assign oFAIL_SY = r_fail_sy;
    assign oFAIL_UY = r_fail_uy;

endmodule

// File: tb/tb_sig_checker.sv
// Bench for sig_checker: table-driven sweeps plus randomized runs, every edge compared against
// a trace-based model of what one sweep should report.
module tb_sig_checker;
    import sig_pkg::*;

    localparam int NRUN = int'(SWEEP_LEN);

    typedef struct {
        logic [7:0] x_start;
        bit         sy_en;
        logic [7:0] sy_x;
        logic [7:0] sy_val;
        bit         uy_en;
        logic [7:0] uy_x;
        logic [7:0] uy_val;
        bit         skip_en;
        logic [7:0] skip_from;
        logic [8:0] exp_err;
        logic [7:0] exp_fx;
        logic [7:0] exp_fsy;
        logic [7:0] exp_fuy;
        bit         exp_seq;
        bit         exp_pass;
    } vec_t;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iSTART = 1'b0;
    logic [7:0] iX = 8'h00, iSY = 8'h00, iUY = 8'h00;
    logic       oBUSY, oDONE, oPASS, oSEQ_ERR;
    logic [8:0] oERR_CNT;
    logic [7:0] oFAIL_X, oFAIL_SY, oFAIL_UY;
    logic [7:0] ref_x = 8'h00;
    logic [7:0] ref_es, ref_eu;

    always #5 iCLK = ~iCLK;

    sig_checker #(.SWEEP_LEN(SWEEP_LEN)) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iSTART   (iSTART),
        .iX       (iX),
        .iSY      (iSY),
        .iUY      (iUY),
        .oBUSY    (oBUSY),
        .oDONE    (oDONE),
        .oPASS    (oPASS),
        .oSEQ_ERR (oSEQ_ERR),
        .oERR_CNT (oERR_CNT),
        .oFAIL_X  (oFAIL_X),
        .oFAIL_SY (oFAIL_SY),
        .oFAIL_UY (oFAIL_UY)
    );

    sig_ref_model u_ref (
        .iX  (ref_x),
        .oES (ref_es),
        .oEU (ref_eu)
    );

    int passes = 0;
    int checks = 0;

    logic [7:0] log_x[$];
    logic [7:0] log_sy[$];
    logic [7:0] log_uy[$];
    int         start_edge = -1;

    logic [7:0] gen_x = 8'h00;
    bit         f_sy_en[256];
    logic [7:0] f_sy_val[256];
    bit         f_uy_en[256];
    logic [7:0] f_uy_val[256];
    bit         skip_en = 1'b0;
    logic [7:0] skip_from = 8'h00;
    bit         skip_done = 1'b0;
    bit         seen_zero = 1'b0;

    vec_t tbl[4];

    function automatic logic [7:0] exp_sy(input logic [7:0] x);
        int a, b;
        a = int'(x[3:0]);
        b = int'(x[7:4]);
        if (a > 7) a -= 16;
        if (b > 7) b -= 16;
        return 8'(a * b);
    endfunction

    function automatic logic [7:0] exp_uy(input logic [7:0] x);
        return 8'(int'(x[3:0]) * int'(x[7:4]));
    endfunction

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s at t=%0t: got %0h, required %0h", what, $time, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Expected outputs after edge e, derived from the logged sample stream of the current run.
    task automatic model_at(input int e, output logic [36:0] v);
        int         v0, last, cnt;
        logic [7:0] fx, fsy, fuy;
        bit         seq, dn, mism;
        v = '0;
        if (start_edge < 0 || e < start_edge) return;
        v0 = -1;
        for (int i = start_edge + 1; i <= e; i++) begin
            if (log_x[i] == 8'h00) begin
                v0 = i;
                break;
            end
        end
        if (v0 < 0) begin
            v = {1'b1, 36'b0};
            return;
        end
        last = (e < v0 + NRUN - 1) ? e : v0 + NRUN - 1;
        cnt = 0;
        fx = 8'h00;
        fsy = 8'h00;
        fuy = 8'h00;
        seq = 1'b0;
        for (int j = v0; j <= last; j++) begin
            mism = (log_sy[j] != exp_sy(log_x[j])) || (log_uy[j] != exp_uy(log_x[j]));
            if (mism) begin
                if (cnt == 0) begin
                    fx = log_x[j];
                    fsy = log_sy[j];
                    fuy = log_uy[j];
                end
                cnt++;
            end
            if (j > v0 && log_x[j] != 8'(log_x[j-1] + 8'd1)) seq = 1'b1;
        end
        dn = (e >= v0 + NRUN - 1);
        v = {!dn, dn, dn && cnt == 0 && !seq, seq, 9'(cnt), fx, fsy, fuy};
    endtask

    function automatic logic [36:0] dut_vec();
        return {oBUSY, oDONE, oPASS, oSEQ_ERR, oERR_CNT, oFAIL_X, oFAIL_SY, oFAIL_UY};
    endfunction

    task automatic clear_faults();
        for (int i = 0; i < 256; i++) begin
            f_sy_en[i] = 1'b0;
            f_uy_en[i] = 1'b0;
            f_sy_val[i] = 8'h00;
            f_uy_val[i] = 8'h00;
        end
        skip_en = 1'b0;
    endtask

    // One upstream sample per cycle: driven on the falling edge, outputs compared after the rise.
    task automatic step(input bit start);
        logic [7:0]  x, sy, uy;
        logic [36:0] pv, ev;
        int          e;
        bit          armable;
        @(negedge iCLK);
        e = log_x.size();
        x = gen_x;
        sy = f_sy_en[x] ? f_sy_val[x] : exp_sy(x);
        uy = f_uy_en[x] ? f_uy_val[x] : exp_uy(x);
        iSTART = start;
        iX = x;
        iSY = sy;
        iUY = uy;
        log_x.push_back(x);
        log_sy.push_back(sy);
        log_uy.push_back(uy);
        if (start && !iRST) begin
            armable = 1'b1;
            if (start_edge >= 0) begin
                model_at(e - 1, pv);
                armable = pv[35];
            end
            if (armable) begin
                start_edge = e;
                seen_zero = 1'b0;
                skip_done = 1'b0;
            end
        end
        if (start_edge >= 0 && e > start_edge && x == 8'h00) seen_zero = 1'b1;
        if (skip_en && !skip_done && seen_zero && x == skip_from) begin
            gen_x = x + 8'd2;
            skip_done = 1'b1;
        end else begin
            gen_x = x + 8'd1;
        end
        @(posedge iCLK);
        #1;
        model_at(e, ev);
        check("edge_outputs", 64'(dut_vec()), 64'(ev));
    endtask

    task automatic run_vec(input vec_t v, input bit hold_start, input bit named);
        clear_faults();
        gen_x = v.x_start;
        if (v.sy_en) begin
            f_sy_en[v.sy_x] = 1'b1;
            f_sy_val[v.sy_x] = v.sy_val;
        end
        if (v.uy_en) begin
            f_uy_en[v.uy_x] = 1'b1;
            f_uy_val[v.uy_x] = v.uy_val;
        end
        skip_en = v.skip_en;
        skip_from = v.skip_from;
        step(1'b1);
        for (int k = 0; k < 700 && !oDONE; k++) step(hold_start);
        check("done_reached", 64'(oDONE), 64'd1);
        if (named) begin
            check("err_cnt", 64'(oERR_CNT), 64'(v.exp_err));
            check("fail_x", 64'(oFAIL_X), 64'(v.exp_fx));
            check("fail_sy", 64'(oFAIL_SY), 64'(v.exp_fsy));
            check("fail_uy", 64'(oFAIL_UY), 64'(v.exp_fuy));
            check("seq_err", 64'(oSEQ_ERR), 64'(v.exp_seq));
            check("pass", 64'(oPASS), 64'(v.exp_pass));
        end
    endtask

    initial begin
        vec_t rv;
        int   k_run;

        tbl[0] = '{8'h37, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00,
                   9'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[1] = '{8'h37, 1'b1, 8'hF3, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00,
                   9'd1, 8'hF3, 8'h00, 8'h2D, 1'b0, 1'b0};
        tbl[2] = '{8'h37, 1'b1, 8'h7F, 8'h00, 1'b1, 8'h10, 8'h01, 1'b0, 8'h00,
                   9'd2, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0};
        tbl[3] = '{8'h37, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h41,
                   9'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        clear_faults();

        #1;
        check("reset_state", 64'(dut_vec()), 64'd0);

        for (int x = 0; x < 256; x++) begin
            ref_x = 8'(x);
            #1;
            check("ref_model", {48'd0, ref_es, ref_eu}, {48'd0, exp_sy(8'(x)), exp_uy(8'(x))});
        end

        @(negedge iCLK);
        iRST = 1'b0;
        repeat (3) step(1'b0);

        for (int i = 0; i < 4; i++) begin
            run_vec(tbl[i], 1'b0, 1'b1);
            repeat (3) step(1'b0);
        end

        // iSTART held high throughout, then re-arms from DONE.
        run_vec(tbl[2], 1'b1, 1'b1);
        step(1'b1);
        check("rearm_err_cnt", 64'(oERR_CNT), 64'd0);
        check("rearm_fail_x", 64'(oFAIL_X), 64'd0);
        check("rearm_fail_uy", 64'(oFAIL_UY), 64'd0);
        check("rearm_busy", 64'(oBUSY), 64'd1);

        // Continue into the re-armed run and reset it at sample 100.
        clear_faults();
        k_run = 0;
        for (int k = 0; k < 600 && k_run < 100; k++) begin
            step(1'b0);
            if (seen_zero) k_run++;
        end
        check("busy_before_reset", 64'(oBUSY), 64'd1);
        #1;
        iRST = 1'b1;
        start_edge = -1;
        #1;
        check("reset_async", 64'(dut_vec()), 64'd0);
        repeat (2) step(1'b0);
        #1;
        iRST = 1'b0;
        repeat (2) step(1'b0);
        run_vec(tbl[0], 1'b0, 1'b1);

        // Reset released while iSTART is already high arms on the first edge after.
        #1;
        iRST = 1'b1;
        start_edge = -1;
        repeat (2) step(1'b1);
        #1;
        iRST = 1'b0;
        step(1'b1);
        check("arm_after_release", 64'(oBUSY), 64'd1);
        for (int k = 0; k < 700 && !oDONE; k++) step(1'b0);
        check("release_run_done", 64'(oDONE), 64'd1);

        for (int r = 0; r < 4; r++) begin
            rv = tbl[0];
            rv.x_start = 8'($urandom_range(0, 255));
            rv.sy_en = 1'($urandom_range(0, 1));
            rv.sy_x = 8'($urandom_range(0, 255));
            rv.sy_val = exp_sy(rv.sy_x) ^ 8'($urandom_range(1, 255));
            rv.uy_en = 1'($urandom_range(0, 1));
            rv.uy_x = 8'($urandom_range(0, 255));
            rv.uy_val = exp_uy(rv.uy_x) ^ 8'($urandom_range(1, 255));
            rv.skip_en = 1'($urandom_range(0, 1));
            rv.skip_from = 8'($urandom_range(0, 255));
            run_vec(rv, 1'($urandom_range(0, 1)), 1'b0);
            repeat (2) step(1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
